// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: parametrised width/depth, fixed wait-state count,
// byte/halfword/word write strobing and a two-cycle ERROR response.
module ahb_lite_mem_slave #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hrst,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic [DATA_W-1:0] hrdata,
    output logic              hreadyout,
    output logic [1:0]        hresp
);

    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int OFF_W  = (LANE_W > 0) ? LANE_W : 1;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(DEPTH * BYTES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t              state;
    logic [3:0]          wait_cnt;
    logic                dp_q;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          size_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                illegal;
    logic [ADDR_W-1:0]   align_mask;
    logic [IDX_W-1:0]    word_idx;
    logic [OFF_W-1:0]    lane_off;
    logic [BYTES-1:0]    byte_en;
    logic                commit;
    logic                rd_done;
    logic                unused;

    assign unused = ^{hburst, hprot, htrans[0]};

    assign accept     = hsel & hready & htrans[1] & hreadyout;
    assign align_mask = (ADDR_W'(1) << hsize) - ADDR_W'(1);
    assign illegal    = (int'(hsize) > LANE_W)
                     || ((haddr & align_mask) != '0)
                     || ({1'b0, haddr} >= SPAN);

    assign word_idx = IDX_W'(addr_q >> LANE_W);
    assign lane_off = addr_q[OFF_W-1:0] & OFF_W'(BYTES - 1);

    // NOTE: every variable in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        byte_en = '0;
        for (int b = 0; b < BYTES; b++)
            byte_en[b] = (b >= int'(lane_off)) && (b < int'(lane_off) + (1 << size_q));
    end

    // Only legal data phases set dp_q, so ERROR beats can never reach memory.
    assign commit  = dp_q & write_q & hreadyout & ~hrst;
    assign rd_done = dp_q & ~write_q & hreadyout;
    assign hrdata  = rd_done ? mem[word_idx] : '0;

    // NOTE: the memory array has no reset; contents survive hrst by design.
    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int b = 0; b < BYTES; b++)
                if (byte_en[b])
                    mem[word_idx][8*b +: 8] <= hwdata[8*b +: 8];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            dp_q      <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            hreadyout <= 1'b1;
            hresp     <= 2'b00;
        end else begin
            case (state)
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state     <= S_IDLE;
                        hreadyout <= 1'b1;
                    end
                end
                S_ERR1: begin
                    state     <= S_ERR2;
                    hreadyout <= 1'b1;
                end
                default: begin
                    // IDLE and ERR2 both complete a beat and may accept the next one.
                    if (accept) begin
                        addr_q  <= haddr;
                        write_q <= hwrite;
                        size_q  <= hsize;
                        if (illegal) begin
                            state     <= S_ERR1;
                            dp_q      <= 1'b0;
                            hreadyout <= 1'b0;
                            hresp     <= 2'b01;
                        end else if (WAIT_STATES > 0) begin
                            state     <= S_WAIT;
                            wait_cnt  <= 4'(WAIT_STATES);
                            dp_q      <= 1'b1;
                            hreadyout <= 1'b0;
                            hresp     <= 2'b00;
                        end else begin
                            state     <= S_IDLE;
                            dp_q      <= 1'b1;
                            hreadyout <= 1'b1;
                            hresp     <= 2'b00;
                        end
                    end else begin
                        state     <= S_IDLE;
                        dp_q      <= 1'b0;
                        hreadyout <= 1'b1;
                        hresp     <= 2'b00;
                    end
                end
            endcase
        end
    end

endmodule
